// File: rtl/cam_in_formatter_if.sv
// Camera pin bundle (sync + stereo data) and tagged pixel / frame report bundle
// for cam_in_formatter. The camera side is the master, the formatter the slave.
interface cam_in_formatter_if #(
  parameter int PIXEL_WIDTH = 8,
  parameter int HCNT_WIDTH  = 11,
  parameter int VCNT_WIDTH  = 10
);
  logic                   fval;
  logic                   lval;
  logic                   dval;
  logic [PIXEL_WIDTH-1:0] data_l;
  logic [PIXEL_WIDTH-1:0] data_r;
  logic                   out_valid;
  logic [PIXEL_WIDTH-1:0] out_data_l;
  logic [PIXEL_WIDTH-1:0] out_data_r;
  logic [HCNT_WIDTH-1:0]  out_x;
  logic [VCNT_WIDTH-1:0]  out_y;
  logic                   out_sof;
  logic                   out_eol;
  logic                   out_eof;
  logic                   frame_done;
  logic [HCNT_WIDTH-1:0]  meas_hact;
  logic [VCNT_WIDTH-1:0]  meas_vact;
  logic [15:0]            frame_cnt;
  logic                   err_geom;

  modport master (
    output fval, lval, dval, data_l, data_r,
    input  out_valid, out_data_l, out_data_r, out_x, out_y, out_sof, out_eol, out_eof,
    input  frame_done, meas_hact, meas_vact, frame_cnt, err_geom
  );

  modport slave (
    input  fval, lval, dval, data_l, data_r,
    output out_valid, out_data_l, out_data_r, out_x, out_y, out_sof, out_eol, out_eof,
    output frame_done, meas_hact, meas_vact, frame_cnt, err_geom
  );
endinterface

// File: rtl/cam_in_formatter.sv
// Camera input stage: registers raw sync/data, tags pixels with X/Y/SOF/EOL/EOF
// and measures frame geometry. Optional check logic: `define CAM_GEOM_CHECK_EN.
module cam_in_formatter #(
  parameter int PIXEL_WIDTH = 8,
  parameter int HCNT_WIDTH  = 11,
  parameter int VCNT_WIDTH  = 10,
  parameter int EXP_HACT    = 320,
  parameter int EXP_VACT    = 480
) (
  input logic               clk,
  input logic               rst_n,
  cam_in_formatter_if.slave cam
);

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [HCNT_WIDTH-1:0] X_MAX = {HCNT_WIDTH{1'b1}};
  localparam logic [HCNT_WIDTH-1:0] X_ONE = {{(HCNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [HCNT_WIDTH-1:0] X_ZERO = {HCNT_WIDTH{1'b0}};
  localparam logic [VCNT_WIDTH-1:0] Y_MAX = {VCNT_WIDTH{1'b1}};
  localparam logic [VCNT_WIDTH-1:0] Y_ONE = {{(VCNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [VCNT_WIDTH-1:0] Y_ZERO = {VCNT_WIDTH{1'b0}};

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic                   primed_r;
  logic                   fval_r;
  logic                   lval_r;
  logic                   dval_r;
  logic                   fval_d_r;
  logic [PIXEL_WIDTH-1:0] data_l_r;
  logic [PIXEL_WIDTH-1:0] data_r_r;
  logic [HCNT_WIDTH-1:0]  x_r;
  logic [VCNT_WIDTH-1:0]  y_r;
  logic [HCNT_WIDTH-1:0]  line_w_r;
  logic                   has_pix_r;

  logic                   fval_rise_s;
  logic                   fval_fall_s;
  logic                   in_frame_s;
  logic                   pix_s;
  logic                   next_qual_s;
  logic                   eol_s;
  logic                   eof_s;
  logic                   sof_s;
  logic [HCNT_WIDTH-1:0]  width_s;
  logic                   err_nxt_s;

  logic                   out_valid_r;
  logic [PIXEL_WIDTH-1:0] out_data_l_r;
  logic [PIXEL_WIDTH-1:0] out_data_r_r;
  logic [HCNT_WIDTH-1:0]  out_x_r;
  logic [VCNT_WIDTH-1:0]  out_y_r;
  logic                   out_sof_r;
  logic                   out_eol_r;
  logic                   out_eof_r;
  logic                   frame_done_r;
  logic [HCNT_WIDTH-1:0]  meas_hact_r;
  logic [VCNT_WIDTH-1:0]  meas_vact_r;
  logic [15:0]            frame_cnt_r;
  logic                   err_geom_r;

  // Stage 1: raw pin capture; primed_r keeps SYNC from trusting the reset value of fval_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed_r <= 1'b0;
      fval_r   <= 1'b0;
      lval_r   <= 1'b0;
      dval_r   <= 1'b0;
      fval_d_r <= 1'b0;
      data_l_r <= {PIXEL_WIDTH{1'b0}};
      data_r_r <= {PIXEL_WIDTH{1'b0}};
    end else begin
      primed_r <= 1'b1;
      fval_r   <= cam.fval;
      lval_r   <= cam.lval;
      dval_r   <= cam.dval;
      fval_d_r <= fval_r;
      data_l_r <= cam.data_l;
      data_r_r <= cam.data_r;
    end
  end

  // Pixel qualification with one-cycle lookahead on the raw pins for EOL/EOF.
  always_comb begin
    fval_rise_s = fval_r & ~fval_d_r;
    fval_fall_s = ~fval_r & fval_d_r;
    in_frame_s  = (state_r == ACTIVE) | ((state_r == IDLE) & fval_rise_s);
    pix_s       = fval_r & lval_r & dval_r & in_frame_s;
    next_qual_s = cam.fval & cam.lval & cam.dval;
    eol_s       = pix_s & ~next_qual_s;
    eof_s       = eol_s & ~cam.fval;
    sof_s       = pix_s & ~has_pix_r;
    if (x_r == X_MAX) begin
      width_s = X_MAX;
    end else begin
      width_s = x_r + X_ONE;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= SYNC;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Frame FSM next state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      SYNC: begin
        if (primed_r && !fval_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SYNC;
        end
      end
      IDLE: begin
        if (fval_rise_s) begin
          state_nxt_s = ACTIVE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACTIVE: begin
        if (fval_fall_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = ACTIVE;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = SYNC;
    endcase
  end

  // Saturating X/Y position and last line width; everything clears outside an open frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r       <= X_ZERO;
      y_r       <= Y_ZERO;
      line_w_r  <= X_ZERO;
      has_pix_r <= 1'b0;
    end else if (pix_s) begin
      has_pix_r <= 1'b1;
      if (eol_s) begin
        x_r      <= X_ZERO;
        line_w_r <= width_s;
        y_r      <= (y_r == Y_MAX) ? y_r : y_r + Y_ONE;
      end else begin
        x_r <= (x_r == X_MAX) ? x_r : x_r + X_ONE;
      end
    end else if (state_r != ACTIVE) begin
      x_r       <= X_ZERO;
      y_r       <= Y_ZERO;
      line_w_r  <= X_ZERO;
      has_pix_r <= 1'b0;
    end
  end

`ifdef CAM_GEOM_CHECK_EN
  localparam logic [HCNT_WIDTH-1:0] EXP_H = HCNT_WIDTH'(EXP_HACT);
  localparam logic [VCNT_WIDTH-1:0] EXP_V = VCNT_WIDTH'(EXP_VACT);

  logic ovf_r;
  logic mism_r;
  logic ovf_hit_s;
  logic line_bad_s;

  always_comb begin
    ovf_hit_s  = pix_s & ((~eol_s & (x_r == X_MAX)) | (eol_s & (y_r == Y_MAX)));
    line_bad_s = eol_s & (width_s != EXP_H);
    err_nxt_s  = mism_r | ovf_r | (y_r != EXP_V);
  end

  // Per-frame overflow and mismatch flags, restarted by SOF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r  <= 1'b0;
      mism_r <= 1'b0;
    end else if (sof_s) begin
      ovf_r  <= ovf_hit_s;
      mism_r <= line_bad_s;
    end else if (pix_s) begin
      ovf_r  <= ovf_r | ovf_hit_s;
      mism_r <= mism_r | line_bad_s;
    end else if (state_r != ACTIVE) begin
      ovf_r  <= 1'b0;
      mism_r <= 1'b0;
    end
  end
`else
  assign err_nxt_s = 1'b0;
`endif

  // Stage 2: tagged pixel outputs and the per-frame report latched in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_data_l_r <= {PIXEL_WIDTH{1'b0}};
      out_data_r_r <= {PIXEL_WIDTH{1'b0}};
      out_x_r      <= X_ZERO;
      out_y_r      <= Y_ZERO;
      out_sof_r    <= 1'b0;
      out_eol_r    <= 1'b0;
      out_eof_r    <= 1'b0;
      frame_done_r <= 1'b0;
      meas_hact_r  <= X_ZERO;
      meas_vact_r  <= Y_ZERO;
      frame_cnt_r  <= 16'd0;
      err_geom_r   <= 1'b0;
    end else begin
      out_valid_r  <= pix_s;
      out_sof_r    <= sof_s;
      out_eol_r    <= eol_s;
      out_eof_r    <= eof_s;
      frame_done_r <= (state_r == DONE);
      if (pix_s) begin
        out_data_l_r <= data_l_r;
        out_data_r_r <= data_r_r;
        out_x_r      <= x_r;
        out_y_r      <= y_r;
      end
      if (state_r == DONE) begin
        meas_hact_r <= line_w_r;
        meas_vact_r <= y_r;
        frame_cnt_r <= frame_cnt_r + 16'd1;
        err_geom_r  <= err_nxt_s;
      end
    end
  end

  assign cam.out_valid  = out_valid_r;
  assign cam.out_data_l = out_data_l_r;
  assign cam.out_data_r = out_data_r_r;
  assign cam.out_x      = out_x_r;
  assign cam.out_y      = out_y_r;
  assign cam.out_sof    = out_sof_r;
  assign cam.out_eol    = out_eol_r;
  assign cam.out_eof    = out_eof_r;
  assign cam.frame_done = frame_done_r;
  assign cam.meas_hact  = meas_hact_r;
  assign cam.meas_vact  = meas_vact_r;
  assign cam.frame_cnt  = frame_cnt_r;
  assign cam.err_geom   = err_geom_r;

endmodule

// File: tb/tb_cam_in_formatter.sv
// Directed bench for cam_in_formatter on a reduced 8x6 active window so whole
// frames fit in a short run; a monitor checks every output pixel against the plan.
module tb_cam_in_formatter;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int HB = 4;
`ifdef CAM_GEOM_CHECK_EN
  localparam logic GEOM_ON = 1'b1;
`else
  localparam logic GEOM_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   cyc_cnt;
  int   sof_cyc;
  int   n_valid;
  int   n_done;
  int   m_x;
  int   m_y;
  int   m_idx;
  int   exp_lines;
  int   exp_w [16];

  cam_in_formatter_if #(.PIXEL_WIDTH(8), .HCNT_WIDTH(11), .VCNT_WIDTH(10)) cif ();

  cam_in_formatter #(
    .PIXEL_WIDTH(8), .HCNT_WIDTH(11), .VCNT_WIDTH(10), .EXP_HACT(W), .EXP_VACT(H)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cam   (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Pixel monitor: compares each strobe with the stimulus plan of the current frame.
  always @(posedge clk) begin
    logic [7:0] exp_d;
    logic       exp_eol;
    #1;
    if (cif.frame_done) n_done++;
    if (cif.out_valid) begin
      n_valid++;
      exp_d   = 8'hA5 + 8'(m_idx);
      exp_eol = (m_y < 16) && (m_x == exp_w[m_y] - 1);
      chk("out_x", 32'(cif.out_x), 32'(m_x));
      chk("out_y", 32'(cif.out_y), 32'(m_y));
      chk("data_r", 32'(cif.out_data_r), 32'(exp_d));
      chk("data_l", 32'(cif.out_data_l), 32'(exp_d + 8'd16));
      chk("sof", 32'(cif.out_sof), 32'(m_x == 0 && m_y == 0));
      chk("eol", 32'(cif.out_eol), 32'(exp_eol));
      chk("eof", 32'(cif.out_eof), 32'(exp_eol && m_y == exp_lines - 1));
      if (m_x == 0 && m_y == 0) chk("latency", 32'(cyc_cnt - sof_cyc), 32'd2);
      m_idx++;
      if (exp_eol) begin
        m_x = 0;
        m_y++;
      end else begin
        m_x++;
      end
    end
  end

  task automatic drive(input logic f, input logic l, input logic d, input logic [7:0] dr);
    cif.fval   = f;
    cif.lval   = l;
    cif.dval   = d;
    cif.data_r = dr;
    cif.data_l = dr + 8'd16;
    @(negedge clk);
  endtask

  // Drives one frame; abort_line >= 0 returns three pixels into that line, mid-frame.
  task automatic run_frame(input int nlines, input int short_line, input int abort_line);
    logic [7:0] d;
    exp_lines = nlines;
    for (int i = 0; i < 16; i++) exp_w[i] = (i == short_line) ? W - 1 : W;
    m_x = 0; m_y = 0; m_idx = 0; n_valid = 0;
    d = 8'hA5;
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    for (int ln = 0; ln < nlines; ln++) begin
      for (int px = 0; px < exp_w[ln]; px++) begin
        if (ln == abort_line && px == 3) return;
        if (ln == 0 && px == 0) sof_cyc = cyc_cnt;
        drive(1'b1, 1'b1, 1'b1, d);
        d = d + 8'd1;
      end
      if (ln == nlines - 1) repeat (HB + 2) drive(1'b0, 1'b0, 1'b0, 8'h00);
      else repeat (HB) drive(1'b1, 1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic raw_lines(input int n);
    for (int ln = 0; ln < n; ln++) begin
      repeat (W) drive(1'b1, 1'b1, 1'b1, 8'h3C);
      repeat (HB) drive(1'b1, 1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic chk_report(input string tag, input int cnt, input int hact, input int vact,
                            input logic err, input int valids, input int dones);
    chk({tag, "_frame_cnt"}, 32'(cif.frame_cnt), 32'(cnt));
    chk({tag, "_meas_hact"}, 32'(cif.meas_hact), 32'(hact));
    chk({tag, "_meas_vact"}, 32'(cif.meas_vact), 32'(vact));
    chk({tag, "_err_geom"}, 32'(cif.err_geom), 32'(err));
    chk({tag, "_valids"}, 32'(n_valid), 32'(valids));
    chk({tag, "_dones"}, 32'(n_done), 32'(dones));
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_valid = 0; n_done = 0;
    m_x = 0; m_y = 0; m_idx = 0; sof_cyc = 0; exp_lines = H;
    for (int i = 0; i < 16; i++) exp_w[i] = W;
    rst_n = 1'b0;
    cif.fval = 1'b1; cif.lval = 1'b0; cif.dval = 1'b0;
    cif.data_l = 8'h00; cif.data_r = 8'h00;

    // Reset while a frame is already running; release mid-frame.
    raw_lines(2);
    chk("rst_valid", 32'(cif.out_valid), 32'd0);
    chk("rst_done", 32'(cif.frame_done), 32'd0);
    chk("rst_x", 32'(cif.out_x), 32'd0);
    chk_report("rst", 0, 0, 0, 1'b0, 0, 0);
    rst_n = 1'b1;
    raw_lines(2);
    repeat (HB + 2) drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("partial_valids", 32'(n_valid), 32'd0);
    chk("partial_dones", 32'(n_done), 32'd0);

    run_frame(H, -1, -1);
    chk_report("f1", 1, W, H, 1'b0, W * H, 1);
    run_frame(H, -1, -1);
    chk_report("f2", 2, W, H, 1'b0, W * H, 2);
    run_frame(H, 3, -1);
    chk_report("short", 3, W, H, GEOM_ON, W * H - 1, 3);
    run_frame(H, -1, -1);
    chk_report("clean", 4, W, H, 1'b0, W * H, 4);

    // DVAL with FVAL low, then an FVAL window whose DVAL pulses all sit outside LVAL.
    n_valid = 0;
    repeat (3) begin
      drive(1'b0, 1'b0, 1'b1, 8'h11);
      drive(1'b0, 1'b1, 1'b1, 8'h22);
      drive(1'b0, 1'b0, 1'b0, 8'h00);
    end
    chk("fval_low_valids", 32'(n_valid), 32'd0);
    chk("fval_low_cnt", 32'(cif.frame_cnt), 32'd4);
    repeat (2) drive(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (4) begin
      drive(1'b1, 1'b0, 1'b1, 8'h33);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
    end
    repeat (HB + 2) drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk_report("empty", 5, 0, 0, GEOM_ON, 0, 5);

    // Asynchronous reset in the middle of line 3.
    run_frame(H, -1, 3);
    chk("pre_rst_valid", 32'(cif.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(cif.out_valid), 32'd0);
    chk("async_x", 32'(cif.out_x), 32'd0);
    chk("async_data_r", 32'(cif.out_data_r), 32'd0);
    chk("async_cnt", 32'(cif.frame_cnt), 32'd0);
    chk("async_hact", 32'(cif.meas_hact), 32'd0);
    chk("async_vact", 32'(cif.meas_vact), 32'd0);
    @(negedge clk);
    n_valid = 0; n_done = 0;
    drive(1'b1, 1'b1, 1'b1, 8'h44);
    drive(1'b1, 1'b1, 1'b1, 8'h45);
    rst_n = 1'b1;
    repeat (3) drive(1'b1, 1'b1, 1'b1, 8'h46);
    repeat (HB) drive(1'b1, 1'b0, 1'b0, 8'h00);
    raw_lines(2);
    repeat (HB + 2) drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("aborted_valids", 32'(n_valid), 32'd0);
    chk("aborted_dones", 32'(n_done), 32'd0);
    run_frame(H, -1, -1);
    chk_report("resume", 1, W, H, 1'b0, W * H, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cam_in_formatter.md
Name: cam_in_formatter

Overview:
- Camera input stage. Sits directly downstream of the stereo camera pins (FVAL/LVAL/DVAL, DATA_L/DATA_R) and feeds the frame buffer / VGA path inside TOP.
- Registers the raw sync and data, drops partial frames after reset, and tags each valid pixel with X/Y coordinates and SOF/EOL/EOF markers.
- Measures the active geometry of every frame and reports it with a frame counter.

Parameters:
PIXEL_WIDTH, 8, width of DATA_L/DATA_R and of the output pixels
HCNT_WIDTH, 11, width of the X counter and the measured width
VCNT_WIDTH, 10, width of the Y counter and the measured height
EXP_HACT, 320, expected valid pixels per line (geometry check)
EXP_VACT, 480, expected valid lines per frame (geometry check)

Ports:
CLK  in  1  camera pixel clock (CCLK domain); single clock
RST_N  in  1  asynchronous active-low reset
FVAL  in  1  frame valid
LVAL  in  1  line valid
DVAL  in  1  data valid
DATA_L  in  PIXEL_WIDTH  left pixel
DATA_R  in  PIXEL_WIDTH  right pixel
OUT_VALID  out  1  pixel strobe
OUT_DATA_L  out  PIXEL_WIDTH  left pixel
OUT_DATA_R  out  PIXEL_WIDTH  right pixel
OUT_X  out  HCNT_WIDTH  pixel column, 0-based
OUT_Y  out  VCNT_WIDTH  pixel row, 0-based
OUT_SOF  out  1  first pixel of frame
OUT_EOL  out  1  last pixel of line
OUT_EOF  out  1  last pixel of frame
FRAME_DONE  out  1  1-cycle pulse when a frame closes
MEAS_HACT  out  HCNT_WIDTH  width of last line of last frame
MEAS_VACT  out  VCNT_WIDTH  line count of last frame
FRAME_CNT  out  16  completed frames, wraps at 0xFFFF->0
ERR_GEOM  out  1  geometry error for last frame

Behaviour:
- Reset: every output is 0; FSM goes to SYNC; all counters are 0. Reset asserted mid-frame aborts that frame with no FRAME_DONE.
- Stage 1 registers all inputs. A pixel is qualified when DVAL&LVAL&FVAL are all 1 in stage 1. DVAL outside LVAL or FVAL is ignored.
- Stage 2 drives the outputs, so latency is 2 CLK from input to OUT_*. EOL/EOF use stage-1 lookahead.
- FSM:
  - SYNC: wait for FVAL=0, then go to IDLE. A frame already in progress at reset is discarded entirely.
  - IDLE: on an FVAL rising edge, go to ACTIVE.
  - ACTIVE: emit pixels. On an FVAL falling edge, go to DONE.
  - DONE: exactly 1 cycle. Pulse FRAME_DONE, update MEAS_*/ERR_GEOM, increment FRAME_CNT, then go to IDLE.
- Frame re-entry: FVAL rising in the same cycle DONE is entered is not possible, because FVAL needs a falling edge first. FVAL rising in the cycle after DONE is accepted.
- Pixel flags:
  - OUT_X increments per qualified pixel.
  - A line ends when the qualified run ends (DVAL or LVAL falls). On the line's last pixel: OUT_EOL=1, X resets to 0, Y increments.
  - OUT_SOF=1 on the first qualified pixel of the frame (X=0, Y=0).
  - OUT_EOF=1 on the last qualified pixel before FVAL falls. It coincides with OUT_EOL.
  - Lines with zero qualified pixels do not increment Y.
- Saturation: X saturates at 2^HCNT_WIDTH-1; Y saturates at 2^VCNT_WIDTH-1. Either saturation sets the internal ovf flag, which reads into ERR_GEOM.
- Frames without pixels: a frame with FVAL high but no qualified pixels still produces FRAME_DONE, with MEAS_HACT=0 and MEAS_VACT=0.
- MEAS_*, FRAME_CNT and ERR_GEOM hold their values between DONE cycles.

Optional Feature:
CAM_GEOM_CHECK_EN
- Defined: a per-frame mismatch flag is cleared at SOF. It is set if any line width differs from EXP_HACT, if the line count differs from EXP_VACT, or on ovf. ERR_GEOM takes this flag's value at DONE.
- Undefined: check logic is removed. ERR_GEOM is tied to 0. Measurements still operate.

Test Plan:
- Reset release with FVAL already high (mid-frame) -> no OUT_VALID until the next FVAL rise; first FRAME_DONE after the first complete frame; FRAME_CNT=1.
- 2 frames, HTOTAL 360 / 320 qualified pixels per line / 480 lines, DATA_L=DATA_R+16 -> 153600 OUT_VALID per frame; SOF at X0/Y0; EOL at X=319; EOF at X=319/Y=479; MEAS_HACT=320; MEAS_VACT=480; ERR_GEOM=0; FRAME_CNT=2.
- Latency check: DATA_R=0xA5 on the first qualified cycle -> OUT_DATA_R=0xA5 with OUT_SOF exactly 2 CLK later.
- Line 100 shortened to 319 pixels (CAM_GEOM_CHECK_EN defined) -> ERR_GEOM=1 at DONE; the next clean frame gives ERR_GEOM=0. With the macro undefined -> ERR_GEOM=0.
- DVAL pulsed while LVAL=0 and while FVAL=0 -> no OUT_VALID, counters unchanged.
- RST_N asserted at line 200 -> all outputs 0 immediately (async); no FRAME_DONE for the aborted frame; normal capture resumes after the next FVAL low-to-high sequence.
